// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock handshake sequencer on the reference clock.
// Pulses PLL reset, waits for lock with timeout and bounded retries,
// demands a lock stability window, then releases the downstream reset.
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       restart,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retries,
    output logic [2:0] state
);

    localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_retries;
    logic          r_lock_meta;
    logic          r_lock_s;
    logic          r_pll_rst;
    logic          r_sys_rst;
    logic          r_ready;
    logic          r_fault;

    state_t        w_next;
    logic [CW-1:0] w_cnt_next;
    logic [3:0]    w_retries_next;
    logic          w_count;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Next-state, counter and retry decisions; restart overrides every transition
    always_comb begin
        w_next         = r_state;
        w_retries_next = r_retries;
        w_count        = 1'b0;
        if (restart) begin
            w_next         = S_RESET;
            w_retries_next = '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_cnt == RST_LAST) w_next = S_WAIT_LOCK;
                    else                   w_count = 1'b1;
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_next = S_STABLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        if (32'(r_retries) == MAX_RETRIES) begin
                            w_next = S_FAULT;
                        end else begin
                            w_next = S_RESET;
                            if (r_retries != 4'hF) w_retries_next = r_retries + 4'd1;
                        end
                    end else begin
                        w_count = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!r_lock_s) begin
                        w_next = S_WAIT_LOCK;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_next         = S_RUN;
                        w_retries_next = '0;
                    end else begin
                        w_count = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) w_next = S_RESET;
                end
                S_FAULT: begin
                    w_next = S_FAULT;
                end
                default: begin
                    w_next = S_RESET;
                end
            endcase
        end
        // Any state entry (including restart into RESET) clears the counter
        if (restart || (w_next != r_state)) w_cnt_next = '0;
        else if (w_count)                   w_cnt_next = r_cnt + 1'b1;
        else                                w_cnt_next = r_cnt;
    end

    // State register with outputs decoded from the next state so they change on the same edge
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RESET;
            r_cnt     <= '0;
            r_retries <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_retries <= w_retries_next;
            r_pll_rst <= (w_next == S_RESET) || (w_next == S_FAULT);
            r_sys_rst <= (w_next != S_RUN);
            r_ready   <= (w_next == S_RUN);
            r_fault   <= (w_next == S_FAULT);
        end
    end

    assign pll_rst = r_pll_rst;
    assign sys_rst = r_sys_rst;
    assign ready   = r_ready;
    assign fault   = r_fault;
    assign retries = r_retries;
    assign state   = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios with literal timing
// expectations, then randomized lock/restart/reset traffic, all compared
// every cycle against a dwell-time reference model.
module tb_pll_reset_sequencer;

    localparam int unsigned RST_CYCLES    = 4;
    localparam int unsigned LOCK_TIMEOUT  = 100;
    localparam int unsigned STABLE_CYCLES = 8;
    localparam int unsigned MAX_RETRIES   = 2;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       restart    = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retries;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .restart   (restart),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fault     (fault),
        .retries   (retries),
        .state     (state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus the number of edges spent in it so far.
    localparam int PH_RESET = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAULT = 4;
    int m_phase   = PH_RESET;
    int m_now     = 0;
    int m_entered = 0;
    int m_tries   = 0;
    bit m_seen1   = 1'b0;   // pll_locked captured one edge ago
    bit m_seen2   = 1'b0;   // pll_locked captured two edges ago

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_phase   = PH_RESET;
            m_now     = 0;
            m_entered = 0;
            m_tries   = 0;
            m_seen1   = 1'b0;
            m_seen2   = 1'b0;
        end else begin
            bit ls;
            int dwell;
            int nxt;
            ls      = m_seen2;
            m_seen2 = m_seen1;
            m_seen1 = pll_locked;
            m_now++;
            dwell = m_now - m_entered;
            nxt   = m_phase;
            if (restart) begin
                nxt     = PH_RESET;
                m_tries = 0;
            end else if (m_phase == PH_RESET) begin
                if (dwell == RST_CYCLES) nxt = PH_WAIT;
            end else if (m_phase == PH_WAIT) begin
                if (ls) nxt = PH_STABLE;
                else if (dwell == LOCK_TIMEOUT) begin
                    if (m_tries == MAX_RETRIES) nxt = PH_FAULT;
                    else begin
                        nxt = PH_RESET;
                        if (m_tries < 15) m_tries++;
                    end
                end
            end else if (m_phase == PH_STABLE) begin
                if (!ls) nxt = PH_WAIT;
                else if (dwell == STABLE_CYCLES) begin
                    nxt     = PH_RUN;
                    m_tries = 0;
                end
            end else if (m_phase == PH_RUN) begin
                if (!ls) nxt = PH_RESET;
            end
            if (restart || nxt != m_phase) m_entered = m_now;
            m_phase = nxt;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge refclk) begin
        check("m_state",   int'(state),   m_phase);
        check("m_pll_rst", int'(pll_rst), int'(m_phase == PH_RESET || m_phase == PH_FAULT));
        check("m_sys_rst", int'(sys_rst), int'(m_phase != PH_RUN));
        check("m_ready",   int'(ready),   int'(m_phase == PH_RUN));
        check("m_fault",   int'(fault),   int'(m_phase == PH_FAULT));
        check("m_retries", int'(retries), m_tries);
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    function automatic int obs(input int sel);
        case (sel)
            0:       return int'(pll_rst);
            1:       return int'(sys_rst);
            2:       return int'(state);
            3:       return int'(ready);
            default: return int'(fault);
        endcase
    endfunction

    // Count edges until the selected output reaches val (bounded)
    task automatic edges_until(input int sel, input int val, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (obs(sel) != val && n < limit);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},   int'(state),   0);
        check({tag, "_pll_rst"}, int'(pll_rst), 1);
        check({tag, "_sys_rst"}, int'(sys_rst), 1);
        check({tag, "_ready"},   int'(ready),   0);
        check({tag, "_fault"},   int'(fault),   0);
        check({tag, "_retries"}, int'(retries), 0);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen2, back, rel;

        // Reset values
        repeat (3) @(posedge refclk);
        #3;
        check_reset_values("rst");

        // Nominal bring-up
        rst = 1'b0;
        edges_until(0, 0, 1000, n);
        check("nom_pllrst_width", n, 4);
        check("nom_state_wait", int'(state), 1);
        repeat (20) tick();
        pll_locked = 1'b1;
        edges_until(1, 0, 1000, n);
        check("nom_release_latency", n, 11);
        check("nom_ready", int'(ready), 1);
        check("nom_retries", int'(retries), 0);
        check("nom_state_run", int'(state), 3);

        // Loss of lock for one cycle while running
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        check("lol_state_t0", int'(state), 3);
        tick();
        check("lol_state_t1", int'(state), 3);
        tick();
        check("lol_state_t2", int'(state), 0);
        check("lol_sys_rst", int'(sys_rst), 1);
        check("lol_ready", int'(ready), 0);
        check("lol_pll_rst", int'(pll_rst), 1);
        edges_until(0, 0, 1000, n);
        check("lol_pllrst_width", n, 4);
        edges_until(3, 1, 1000, n);
        check("lol_relock_ready", int'(ready), 1);
        check("lol_relock_retries", int'(retries), 0);

        // Timeout into fault with lock held low
        pll_locked = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("to_restart_state", int'(state), 0);
        for (int k = 0; k < 3; k++) begin
            edges_until(0, 0, 1000, n);
            check($sformatf("to_pulse%0d_width", k), n, 4);
            check($sformatf("to_pulse%0d_retries", k), int'(retries), k);
            edges_until(0, 1, 1000, n);
            check($sformatf("to_window%0d_len", k), n, 100);
        end
        check("to_fault", int'(fault), 1);
        check("to_fault_state", int'(state), 4);
        check("to_fault_sys_rst", int'(sys_rst), 1);
        check("to_fault_retries", int'(retries), 2);
        repeat (10) tick();
        check("to_fault_hold_state", int'(state), 4);
        check("to_fault_hold_pll_rst", int'(pll_rst), 1);

        // Restart out of fault
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rf_state", int'(state), 0);
        check("rf_fault", int'(fault), 0);
        check("rf_retries", int'(retries), 0);

        // Restart coinciding with the timeout edge
        edges_until(0, 0, 1000, n);
        check("rt_pllrst_width", n, 4);
        repeat (99) tick();
        check("rt_pre_state", int'(state), 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rt_state", int'(state), 0);
        check("rt_retries", int'(retries), 0);

        // Short lock glitch in WAIT_LOCK, held low past the original deadline
        edges_until(0, 0, 1000, n);
        repeat (10) tick();
        seen2 = 1'b0; back = 1'b0; rel = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < 95; i++) begin
            tick();
            if (i == 4) pll_locked = 1'b0;
            if (state == 3'd2) seen2 = 1'b1;
            if (seen2 && state == 3'd1) back = 1'b1;
            if (!sys_rst) rel = 1'b1;
        end
        check("gl_saw_stable", int'(seen2), 1);
        check("gl_back_to_wait", int'(back), 1);
        check("gl_no_release", int'(rel), 0);
        check("gl_still_wait", int'(state), 1);
        check("gl_retries", int'(retries), 0);
        pll_locked = 1'b1;
        edges_until(1, 0, 1000, n);
        check("gl_release_latency", n, 11);

        // Asynchronous reset while in STABLE
        restart = 1'b1;
        tick();
        restart = 1'b0;
        edges_until(0, 0, 1000, n);
        edges_until(2, 2, 100, n);
        check("ar_in_stable", int'(state), 2);
        #4;
        rst = 1'b1;
        #1;
        check_reset_values("arst");
        #3;
        rst = 1'b0;
        edges_until(0, 0, 1000, n);
        check("ar_pllrst_width", n, 4);
        edges_until(1, 0, 1000, n);
        check("ar_release", n, 1 + STABLE_CYCLES);

        // Randomized traffic, checked by the model every cycle
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            case ($urandom_range(0, 3))
                0: begin pll_locked = 1'b0; len = $urandom_range(1, 350); end
                1: begin pll_locked = 1'b1; len = $urandom_range(1, 12); end
                2: begin pll_locked = 1'b1; len = $urandom_range(20, 200); end
                default: begin pll_locked = 1'b0; len = $urandom_range(1, 3); end
            endcase
            for (int i = 0; i < len; i++) begin
                tick();
                restart = ($urandom_range(0, 299) == 0);
            end
            if ($urandom_range(0, 29) == 0) begin
                #3 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        restart = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sequences the reset and lock handshake of the board PLL on the 50 MHz reference clock. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to stay high for a stability window. Only then does it release the system reset to downstream logic. Loss of lock forces system reset and a full re-sequence. Persistent failure parks the block in a FAULT state.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, refclk cycles to wait for lock per attempt (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before release
MAX_RETRIES, 3, timed-out attempts re-tried before FAULT (0 = a single attempt, no retry)

Ports:
refclk  in  1  reference clock, sole clock domain
rst  in  1  asynchronous, active-high reset
restart  in  1  synchronous pulse: abandon current state and re-sequence
pll_locked  in  1  PLL LOCKED, asynchronous to refclk
pll_rst  out  1  drives PLL RST
sys_rst  out  1  active-high reset to downstream logic
ready  out  1  high only in RUN
fault  out  1  high only in FAULT
retries  out  4  timed-out attempts in the current sequence (saturates at 15)
state  out  3  debug: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4

Behaviour:
- Reset values (rst high) are as follows.
  - state=RESET, pll_rst=1, sys_rst=1, ready=0, fault=0, retries=0.
  - All counters are 0, and the sync flops are 0.
- Outputs are registered and update on the same edge as the state register. No combinational glitches are permitted.
  - pll_rst=1 in RESET and FAULT.
  - sys_rst=1 in every state except RUN.
- Synchronizer: pll_locked passes through 2 flops to produce lock_s. Added latency is 2 cycles.
- A single counter cnt is cleared on every state entry. Its width is sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- RESET: cnt increments each cycle. When cnt==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - If lock_s=1, go to STABLE.
  - Else, if cnt==LOCK_TIMEOUT-1:
    - if retries==MAX_RETRIES, go to FAULT;
    - otherwise retries+=1 and go to RESET.
  - Else cnt+=1.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK. The timeout restarts and retries are unchanged.
  - If cnt==STABLE_CYCLES-1 with lock_s=1, go to RUN and clear retries.
  - Otherwise cnt+=1.
- RUN: if lock_s=0, go to RESET; sys_rst asserts on that same edge. Retries remain 0.
- FAULT is terminal. Exit only via restart or rst.
- restart=1 in any state goes to RESET, clears retries and cnt, and deasserts fault. This holds even when restart is already in RESET. restart has priority over all simultaneous transitions (timeout, lock change, stability completion).
- rst asserted mid-operation immediately forces the reset values (asynchronous). Sequencing resumes from RESET on the first edge after deassertion.
- lock_s glitching high in WAIT_LOCK for fewer than STABLE_CYCLES never releases sys_rst.
- Minimum latency from pll_locked rising (sampled at edge t) to sys_rst falling is 2 cycles (sync) plus 1 cycle (WAIT_LOCK→STABLE) plus STABLE_CYCLES cycles.

Test Plan:
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal: release rst, and raise pll_locked 20 cycles after pll_rst falls.
  - Required: pll_rst high exactly 4 cycles.
  - sys_rst falls, and ready rises, exactly 11 cycles after pll_locked sampled high.
  - retries=0.
- Timeout/fault: hold pll_locked=0 throughout.
  - Required: 3 pll_rst pulses of 4 cycles each, separated by 100-cycle WAIT_LOCK windows.
  - retries goes 0→1→2.
  - fault=1 and state=4 after the third timeout; pll_rst then held 1 and sys_rst=1.
- Stability glitch: in WAIT_LOCK, drive pll_locked high for 5 cycles then low, then high permanently.
  - Required: state 1→2→1 (timeout restarted), and no sys_rst release.
  - Release occurs 11 cycles after the final rise.
- Loss of lock: in RUN, drop pll_locked for 1 cycle.
  - Required: 2 cycles later state=0, sys_rst=1, ready=0, and pll_rst=1 for 4 cycles.
  - Re-lock then releases again with retries=0.
- Restart priority: in FAULT, pulse restart=1 for 1 cycle.
  - Required: next edge state=0, fault=0, retries=0.
  - Repeat with restart asserted on the timeout cycle of WAIT_LOCK: state=0, retries=0 (not incremented).
- Async reset mid-run: assert rst between edges while in STABLE.
  - Required: outputs immediately take reset values without waiting for an edge.
  - Full sequence restarts after deassertion.
